// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor types, counter encodings and saturating update
package bp_pkg;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        UPD_WR = 2'd2
    } phtState_e;

    function automatic logic [1:0] sat_update(input logic [1:0] counter, input logic taken);
        if (taken) begin
            return (counter == STRONG_T) ? STRONG_T : counter + 2'd1;
        end
        return (counter == STRONG_NT) ? STRONG_NT : counter - 2'd1;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// rtl/pht_upd_fifo.sv - synchronous FIFO holding pending {index, taken} updates
module pht_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    cnt;
    logic             doPush;
    logic             doPop;

    // Wrap explicitly so non-power-of-two depths work
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pht_ctrl.sv
// rtl/pht_ctrl.sv - PHT RAM owner: init sweep, lookup/update arbitration, counter RMW
module pht_ctrl
    import bp_pkg::*;
#(
    parameter int         PHT_DEPTH  = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_VALUE = 2'b10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    input  logic [PHT_DEPTH-1:0] lookup_index,
    output logic                 lookup_ready,
    output logic                 lookup_pred_valid,
    output logic                 lookup_pred,
    input  logic                 upd_valid,
    input  logic [PHT_DEPTH-1:0] upd_index,
    input  logic                 upd_taken,
    output logic                 upd_ready,
    output logic                 init_done,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [PHT_DEPTH-1:0] ram_addr,
    output logic [1:0]           ram_wdata,
    input  logic [1:0]           ram_rdata
);

    localparam logic [PHT_DEPTH-1:0] LAST_ADDR = '1;

    phtState_e            state;
    phtState_e            nextState;
    logic [PHT_DEPTH-1:0] sweep;
    logic [PHT_DEPTH-1:0] rmwIndex;
    logic                 rmwTaken;
    logic                 predPending;
    logic                 predHold;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 fifoPop;
    logic                 fifoPush;
    logic [PHT_DEPTH:0]   fifoHead;

    assign fifoPush = upd_valid && upd_ready;

    pht_upd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PHT_DEPTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pushData ({upd_index, upd_taken}),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Outputs are forced quiet while rst is high, even if the state register still holds UPD_WR
    always_comb begin
        nextState    = state;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        lookup_ready = 1'b0;
        fifoPop      = 1'b0;
        upd_ready    = 1'b0;
        init_done    = 1'b0;
        if (!rst) begin
            upd_ready = (state != INIT) && !fifoFull;
            init_done = (state != INIT);
            unique case (state)
                INIT: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = sweep;
                    ram_wdata = INIT_VALUE;
                    if (sweep == LAST_ADDR) begin
                        nextState = RUN;
                    end
                end
                RUN: begin
                    if (fifoFull || (!lookup_valid && !fifoEmpty)) begin
                        ram_en    = 1'b1;
                        ram_addr  = fifoHead[PHT_DEPTH:1];
                        fifoPop   = 1'b1;
                        nextState = UPD_WR;
                    end else if (lookup_valid) begin
                        ram_en       = 1'b1;
                        ram_addr     = lookup_index;
                        lookup_ready = 1'b1;
                    end
                end
                UPD_WR: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = rmwIndex;
                    ram_wdata = sat_update(ram_rdata, rmwTaken);
                    nextState = RUN;
                end
                default: nextState = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            sweep       <= '0;
            rmwIndex    <= '0;
            rmwTaken    <= 1'b0;
            predPending <= 1'b0;
            predHold    <= 1'b0;
        end else begin
            state       <= nextState;
            predPending <= lookup_ready;
            if (state == INIT) begin
                sweep <= sweep + PHT_DEPTH'(1);
            end
            if (fifoPop) begin
                rmwIndex <= fifoHead[PHT_DEPTH:1];
                rmwTaken <= fifoHead[0];
            end
            if (predPending) begin
                predHold <= ram_rdata[1];
            end
        end
    end

    assign lookup_pred_valid = !rst && predPending;
    assign lookup_pred       = rst ? 1'b0 : (predPending ? ram_rdata[1] : predHold);

endmodule
